// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors, legal prescale ratios
// and the 2-of-3 majority voter used by both link directions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing engine for the UART receiver: per-bit edge counter, data-bit counter and
// a 3-sample majority voter around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int Data_Width = 8,
    parameter int Prescale_W = 6,
    localparam int BW = (Data_Width > 1) ? $clog2(Data_Width) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    input  logic [Prescale_W-1:0] presc_i,
    input  logic                  start_i,
    input  logic                  active_i,
    input  logic                  data_phase_i,
    output logic                  sampled_bit_o,
    output logic                  sample_done_o,
    output logic                  bit_end_o,
    output logic [BW-1:0]         bit_cnt_o
);

    localparam logic [Prescale_W-1:0] ONE = Prescale_W'(1);

    logic [Prescale_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [Prescale_W-1:0] half;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;

    assign half          = presc_i >> 1;
    assign sample_done_o = active_i && (edge_cnt_q == half + ONE);
    assign bit_end_o     = active_i && (edge_cnt_q == presc_i - ONE);
    assign sampled_bit_o = majority3(s0_q, s1_q, rx_i);
    assign bit_cnt_o     = bit_cnt_q;

    // The start-detect cycle is edge 0 of the start bit, so the counter resumes at 1.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (start_i) begin
            edge_cnt_d = ONE;
        end else if (!active_i || bit_end_o) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + ONE;
        end

        s0_d = s0_q;
        s1_d = s1_q;
        if (active_i && (edge_cnt_q == half - ONE)) s0_d = rx_i;
        if (active_i && (edge_cnt_q == half))       s1_d = rx_i;

        bit_cnt_d = bit_cnt_q;
        if (!data_phase_i) begin
            bit_cnt_d = '0;
        end else if (bit_end_o) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first shift-in, optional parity and stop-bit check,
// with one-cycle Data_Valid / Par_Err / Stp_Err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int Data_Width = 8,
    parameter int Prescale_W = 6
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_In,
    input  logic [Prescale_W-1:0] Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Type,
    output logic [Data_Width-1:0] P_Data,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  Busy
);

    localparam int BW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(Data_Width - 1);

    uart_state_e state_q, state_d;

    logic [Prescale_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic [Data_Width-1:0] shift_q, shift_d;
    logic [Data_Width-1:0] p_data_q, p_data_d;
    logic                  par_bad_q, par_bad_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  start_det, active, data_phase, parity_phase, stop_decide;
    logic                  sampled_bit, sample_done, bit_end;
    logic [BW-1:0]         bit_cnt;

    uart_rx_sampler #(
        .Data_Width (Data_Width),
        .Prescale_W (Prescale_W)
    ) u_sampler (
        .clk_i         (clk),
        .rst_ni        (RST),
        .rx_i          (RX_In),
        .presc_i       (presc_q),
        .start_i       (start_det),
        .active_i      (active),
        .data_phase_i  (data_phase),
        .sampled_bit_o (sampled_bit),
        .sample_done_o (sample_done),
        .bit_end_o     (bit_end),
        .bit_cnt_o     (bit_cnt)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (!RX_In) state_d = START;
            START:  begin
                if (sample_done && sampled_bit) state_d = IDLE;
                else if (bit_end)               state_d = DATA;
            end
            DATA:   if (bit_end && (bit_cnt == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (sample_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_det    = (state_q == IDLE) && !RX_In;
        active       = (state_q != IDLE);
        data_phase   = (state_q == DATA);
        parity_phase = (state_q == PARITY);
        stop_decide  = (state_q == STOP) && sample_done;
        Busy         = active;
    end

    // Frame settings are frozen at start detection; a parity error outranks a stop error.
    always_comb begin
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        p_data_d   = p_data_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;

        if (start_det) begin
            presc_d    = Prescale;
            par_en_d   = Par_En;
            par_type_d = Par_Type;
            par_bad_d  = 1'b0;
        end
        if (data_phase && sample_done) shift_d[bit_cnt] = sampled_bit;
        if (parity_phase && sample_done) begin
            par_bad_d = sampled_bit != ((^shift_q) ^ (par_type_q == PAR_ODD));
        end
        if (stop_decide) begin
            if (par_bad_q) begin
                par_err_d = 1'b1;
            end else if (!sampled_bit) begin
                stp_err_d = 1'b1;
            end else begin
                valid_d  = 1'b1;
                p_data_d = shift_q;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            p_data_q   <= p_data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    assign P_Data     = p_data_q;
    assign Data_Valid = valid_q;
    assign Par_Err    = par_err_q;
    assign Stp_Err    = stp_err_q;

endmodule
